// File: rtl/mult6x6_pp_accum_if.sv
// Handshake bundle between the digit-product source, the recombine/accumulate stage and the requant consumer.
// The master side drives the product sets and out_ready; the slave side is mult6x6_pp_accum.
interface mult6x6_pp_accum_if #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [6:0]       pp_hh;
    logic [6:0]       pp_hl;
    logic [6:0]       pp_lh;
    logic [6:0]       pp_ll;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_forced;
    logic             out_sat;

    modport master (
        output in_valid, in_last, pp_hh, pp_hl, pp_lh, pp_ll, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_forced, out_sat
    );

    modport slave (
        input  in_valid, in_last, pp_hh, pp_hl, pp_lh, pp_ll, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_forced, out_sat
    );
endinterface

// File: rtl/mult6x6_pp_accum.sv
// Recombines four 3x3 digit products into a 12-bit product and accumulates one kernel window.
// Optional macro MPP_ACC_SAT_EN: saturating accumulation with a sticky per-window out_sat flag.
module mult6x6_pp_accum #(
    parameter int ACC_W     = 20,
    parameter int MAX_TERMS = 64,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    mult6x6_pp_accum_if.slave    bus
);

    function automatic logic [11:0] sext7_12(input logic [6:0] v);
        return {{5{v[6]}}, v};
    endfunction

    logic             r_s1_valid;
    logic             r_s1_last;
    logic [11:0]      r_s1_prod;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_forced;
    logic             r_out_sat;

    logic [11:0]      w_prod12;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_close;
    logic             w_s2_go;
    logic             w_s2_fire;
    logic             w_in_ready;
    logic [ACC_W-1:0] w_sum;
    logic             w_win_sat;

    // S1 recombine and S2 control; a stall only arises when a closing term meets a held result
    always_comb begin
        w_prod12   = (sext7_12(bus.pp_hh) << 6) + (sext7_12(bus.pp_hl) << 3)
                   + (sext7_12(bus.pp_lh) << 3) + sext7_12(bus.pp_ll);
        w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_close    = r_s1_last || (w_cnt_inc == CNT_W'(MAX_TERMS));
        w_s2_go    = !(w_close && r_out_valid && !bus.out_ready);
        w_s2_fire  = r_s1_valid && w_s2_go;
        w_in_ready = !r_s1_valid || w_s2_go;
    end

`ifdef MPP_ACC_SAT_EN
    logic [ACC_W:0] w_sum_wide;
    logic           w_clamp;
    logic           r_sat;

    // one guard bit exposes overflow so the sum can clamp to the signed range
    always_comb begin
        w_sum_wide = (ACC_W+1)'(signed'(r_acc)) + (ACC_W+1)'(signed'(r_s1_prod));
        if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
            w_clamp = 1'b1;
            w_sum   = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_clamp = 1'b0;
            w_sum   = w_sum_wide[ACC_W-1:0];
        end
        w_win_sat = r_sat || w_clamp;
    end

    // sticky window saturation flag, cleared when the window closes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_s2_fire) begin
            r_sat <= w_close ? 1'b0 : w_win_sat;
        end else begin
            r_sat <= r_sat;
        end
    end
`else
    // wrapping accumulation, no saturation reporting
    always_comb begin
        w_sum     = r_acc + ACC_W'(signed'(r_s1_prod));
        w_win_sat = 1'b0;
    end
`endif

    // pipeline state: S1 product register, S2 accumulator and the held window result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_prod    <= 12'd0;
            r_acc        <= {ACC_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_acc    <= {ACC_W{1'b0}};
            r_out_cnt    <= {CNT_W{1'b0}};
            r_out_forced <= 1'b0;
            r_out_sat    <= 1'b0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_prod <= w_prod12;
                    r_s1_last <= bus.in_last;
                end
            end
            if (w_s2_fire) begin
                if (w_close) begin
                    r_out_acc    <= w_sum;
                    r_out_cnt    <= w_cnt_inc;
                    r_out_forced <= !r_s1_last;
                    r_out_sat    <= w_win_sat;
                    r_acc        <= {ACC_W{1'b0}};
                    r_cnt        <= {CNT_W{1'b0}};
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc;
                end
            end
            // a new result landing in the same cycle as the handoff keeps out_valid high
            if (w_s2_fire && w_close) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_acc    = r_out_acc;
    assign bus.out_cnt    = r_out_cnt;
    assign bus.out_forced = r_out_forced;
    assign bus.out_sat    = r_out_sat;

endmodule

// File: tb/tb_mult6x6_pp_accum.sv
// Directed bench for mult6x6_pp_accum: a 20-bit instance for the main scenarios and a 12-bit
// instance for the overflow case (expectations follow MPP_ACC_SAT_EN).
module tb_mult6x6_pp_accum;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // free-running cycle counter for throughput checks
    always @(posedge clk) cyc <= cyc + 1;

    mult6x6_pp_accum_if #(.ACC_W(20), .CNT_W(7)) bus();
    mult6x6_pp_accum_if #(.ACC_W(12), .CNT_W(7)) bus12();

    mult6x6_pp_accum #(.ACC_W(20), .MAX_TERMS(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mult6x6_pp_accum #(.ACC_W(12), .MAX_TERMS(64), .CNT_W(7)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    task automatic send(input logic [6:0] hh, input logic [6:0] hl, input logic [6:0] lh,
                        input logic [6:0] ll, input logic last, input string name);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.pp_hh = hh; bus.pp_hl = hl; bus.pp_lh = lh; bus.pp_ll = ll;
        bus.in_last = last;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_accept: in_ready actual=%0b required=1", name, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pop(input logic signed [19:0] eacc, input logic [6:0] ecnt,
                       input logic ef, input logic es, input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: out_valid actual=%0b required=1", name, bus.out_valid);
        end
        total++;
        if (bus.out_acc !== eacc) begin
            bad++;
            $display("FAIL %s_acc: out_acc actual=%0d required=%0d", name, $signed(bus.out_acc), eacc);
        end
        total++;
        if (bus.out_cnt !== ecnt) begin
            bad++;
            $display("FAIL %s_cnt: out_cnt actual=%0d required=%0d", name, bus.out_cnt, ecnt);
        end
        total++;
        if (bus.out_forced !== ef || bus.out_sat !== es) begin
            bad++;
            $display("FAIL %s_flags: forced/sat actual=%0b/%0b required=%0b/%0b",
                     name, bus.out_forced, bus.out_sat, ef, es);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_acc !== 20'd0 || bus.out_cnt !== 7'd0 ||
            bus.out_forced !== 1'b0 || bus.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: valid/acc/cnt/forced/sat actual=%0b/%0d/%0d/%0b/%0b required=0/0/0/0/0",
                     bus.out_valid, bus.out_acc, bus.out_cnt, bus.out_forced, bus.out_sat);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: actual=%0b required=1", bus.in_ready);
        end
    endtask

    task automatic test_extreme();
        send(-7'sd28, -7'sd28, 7'd0, 7'd0, 1'b1, "extreme");
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL extreme_lat_t1: out_valid actual=%0b required=0", bus.out_valid);
        end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL extreme_lat_t2: out_valid actual=%0b required=1", bus.out_valid);
        end
        pop(-20'sd2016, 7'd1, 1'b0, 1'b0, "extreme");
    endtask

    task automatic test_window3();
        send(7'd21, 7'd21, 7'd49, 7'd49, 1'b0, "w3_a");
        send(-7'sd28, -7'sd28, 7'd0, 7'd0, 1'b0, "w3_b");
        send(7'd0, 7'd0, 7'd0, 7'd5, 1'b1, "w3_c");
        pop(-20'sd58, 7'd3, 1'b0, 1'b0, "w3");
    endtask

    task automatic test_forced();
        for (int i = 0; i < 64; i++) send(7'd0, 7'd0, 7'd0, 7'd1, 1'b0, "forced_term");
        send(7'd0, 7'd0, 7'd0, 7'd2, 1'b1, "forced_next");
        pop(20'sd64, 7'd64, 1'b1, 1'b0, "forced");
        pop(20'sd2, 7'd1, 1'b0, 1'b0, "forced_next");
    endtask

    task automatic test_stall();
        send(7'd0, 7'd0, 7'd0, 7'd3, 1'b1, "stall_a");
        repeat (3) @(negedge clk);
        send(7'd0, 7'd0, 7'd0, 7'd4, 1'b1, "stall_b");
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_in_ready: actual=%0b required=0", bus.in_ready);
        end
        total++;
        if (bus.out_acc !== 20'd3) begin
            bad++;
            $display("FAIL stall_hold: out_acc actual=%0d required=3", bus.out_acc);
        end
        pop(20'sd3, 7'd1, 1'b0, 1'b0, "stall_a");
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 20'd4) begin
            bad++;
            $display("FAIL stall_reload: valid/acc actual=%0b/%0d required=1/4", bus.out_valid, bus.out_acc);
        end
        pop(20'sd4, 7'd1, 1'b0, 1'b0, "stall_b");
        send(7'd0, 7'd0, 7'd0, 7'd5, 1'b1, "stall_c");
        pop(20'sd5, 7'd1, 1'b0, 1'b0, "stall_c");
        repeat (3) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_nodup: out_valid actual=%0b required=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] q[$];
        int c0;
        int c1;
        q.delete();
        bus.out_ready = 1'b1;
        c0 = cyc;
        c1 = cyc;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(7'd0, 7'd0, 7'd0, 7'(i), 1'b1, "b2b");
                c1 = cyc;
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) q.push_back(bus.out_acc);
                end
            end
        join
        bus.out_ready = 1'b0;
        total++;
        if (c1 - c0 != 4) begin
            bad++;
            $display("FAIL b2b_rate: cycles actual=%0d required=4", c1 - c0);
        end
        total++;
        if (q.size() != 4) begin
            bad++;
            $display("FAIL b2b_count: results actual=%0d required=4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q[i] !== 20'(i + 1)) begin
                    bad++;
                    $display("FAIL b2b_order: result %0d actual=%0d required=%0d", i, q[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        send(7'd0, 7'd0, 7'd0, 7'd9, 1'b1, "rmid_a");
        send(7'd0, 7'd0, 7'd0, 7'd1, 1'b0, "rmid_t1");
        send(7'd0, 7'd0, 7'd0, 7'd1, 1'b0, "rmid_t2");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_acc !== 20'd0 || bus.out_cnt !== 7'd0 ||
            bus.out_forced !== 1'b0 || bus.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL rmid_out: valid/acc/cnt actual=%0b/%0d/%0d required=0/0/0",
                     bus.out_valid, bus.out_acc, bus.out_cnt);
        end
        send(7'd0, 7'd0, 7'd0, 7'd7, 1'b1, "rmid_new");
        pop(20'sd7, 7'd1, 1'b0, 1'b0, "rmid_new");
    endtask

    task automatic wait12(input string name);
        int n;
        n = 0;
        while (!bus12.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus12.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: out_valid actual=%0b required=1", name, bus12.out_valid);
        end
    endtask

    task automatic test_sat();
        logic signed [11:0] exp_acc;
        logic               exp_sat;
`ifdef MPP_ACC_SAT_EN
        exp_acc = -12'sd2048;
        exp_sat = 1'b1;
`else
        exp_acc = 12'sd64;
        exp_sat = 1'b0;
`endif
        @(negedge clk);
        total++;
        if (bus12.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL sat_in_ready: actual=%0b required=1", bus12.in_ready);
        end
        bus12.in_valid = 1'b1;
        bus12.pp_hh = -7'sd28; bus12.pp_hl = -7'sd28; bus12.pp_lh = 7'd0; bus12.pp_ll = 7'd0;
        bus12.in_last = 1'b0;
        @(posedge clk);
        #1;
        bus12.in_last = 1'b1;
        @(posedge clk);
        #1;
        bus12.in_valid = 1'b0;
        wait12("sat");
        total++;
        if (bus12.out_acc !== exp_acc || bus12.out_sat !== exp_sat) begin
            bad++;
            $display("FAIL sat_result: acc/sat actual=%0d/%0b required=%0d/%0b",
                     $signed(bus12.out_acc), bus12.out_sat, exp_acc, exp_sat);
        end
        bus12.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus12.out_ready = 1'b0;
        bus12.in_valid = 1'b1;
        bus12.pp_hh = 7'd0; bus12.pp_hl = 7'd0; bus12.pp_ll = 7'd1;
        bus12.in_last = 1'b1;
        @(posedge clk);
        #1;
        bus12.in_valid = 1'b0;
        wait12("sat_clear");
        total++;
        if (bus12.out_acc !== 12'd1 || bus12.out_sat !== 1'b0 || bus12.out_cnt !== 7'd1) begin
            bad++;
            $display("FAIL sat_clear: acc/sat/cnt actual=%0d/%0b/%0d required=1/0/1",
                     bus12.out_acc, bus12.out_sat, bus12.out_cnt);
        end
        bus12.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus12.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus.pp_hh = 7'd0; bus.pp_hl = 7'd0; bus.pp_lh = 7'd0; bus.pp_ll = 7'd0;
        bus12.in_valid = 1'b0; bus12.in_last = 1'b0; bus12.out_ready = 1'b0;
        bus12.pp_hh = 7'd0; bus12.pp_hl = 7'd0; bus12.pp_lh = 7'd0; bus12.pp_ll = 7'd0;
        test_reset();
        test_extreme();
        test_window3();
        test_forced();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
